// File: rtl/trolley_motor_pkg.sv
// Shared definitions for the trolley motor driver.
//   motor_state_e : per-channel FSM state (also exported for debug)
//   CMD_*         : bit positions inside a 3-bit motor command word
//   duty_width    : bit width needed to hold values 0..max_value
package trolley_motor_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STOP  = 3'd2,
    DEAD  = 3'd3,
    ESTOP = 3'd4
  } motor_state_e;

  localparam int CMD_EN  = 2;
  localparam int CMD_DIR = 1;
  localparam int CMD_SPD = 0;

  function automatic int duty_width(input int max_value);
    if (max_value < 1) return 1;
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/trolley_motor_driver_if.sv
// Bundle of command, status and H-bridge pins between the trolley system
// and the motor driver.
//   master : drives motor_l_cmd, motor_r_cmd, prox_stop; observes the rest
//   slave  : the driver; observes commands, drives bridge pins and status
// There is no valid/ready handshake on this bundle: command words and
// prox_stop are level signals, held by the master for as long as they
// apply and sampled by the slave on every rising clock edge. The bridge
// outputs, estop_latched, busy and the state_l/state_r debug taps are
// level outputs that are valid in every cycle.
interface trolley_motor_driver_if;
  import trolley_motor_pkg::*;

  logic [2:0]   motor_l_cmd;
  logic [2:0]   motor_r_cmd;
  logic         prox_stop;
  logic         motor_l_in_a;
  logic         motor_l_in_b;
  logic         motor_l_pwm;
  logic         motor_r_in_a;
  logic         motor_r_in_b;
  logic         motor_r_pwm;
  logic         estop_latched;
  logic [1:0]   busy;
  motor_state_e state_l;
  motor_state_e state_r;

  modport master (
    output motor_l_cmd, motor_r_cmd, prox_stop,
    input  motor_l_in_a, motor_l_in_b, motor_l_pwm,
    input  motor_r_in_a, motor_r_in_b, motor_r_pwm,
    input  estop_latched, busy, state_l, state_r
  );

  modport slave (
    input  motor_l_cmd, motor_r_cmd, prox_stop,
    output motor_l_in_a, motor_l_in_b, motor_l_pwm,
    output motor_r_in_a, motor_r_in_b, motor_r_pwm,
    output estop_latched, busy, state_l, state_r
  );

endinterface

// File: rtl/motor_channel.sv
// One H-bridge channel: FSM (IDLE/RUN/STOP/DEAD/ESTOP), soft-start ramp
// duty, applied (PWM) duty register and reversal dead-time counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   cmd        : registered command word {en, dir, spd}
//   wrap       : shared PWM counter is at its last count this cycle
//   tick       : shared ramp step strobe
//   estop_set  : raw proximity stop, forces ESTOP at the next edge
//   estop_clr  : e-stop release condition, ESTOP -> IDLE
//   in_a, in_b : bridge direction inputs (both 1 = brake)
//   duty       : applied duty, compared against the shared PWM counter
//   busy       : channel not in IDLE
//   state      : FSM state (debug)
module motor_channel
  import trolley_motor_pkg::*;
#(
  parameter  int PWM_PERIOD      = 2500,
  parameter  int HALF_DUTY       = 1250,
  parameter  int RAMP_INC        = 125,
  parameter  int DEADTIME_CYCLES = 50000,
  localparam int DW              = duty_width(PWM_PERIOD),
  localparam int TW              = duty_width(DEADTIME_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    cmd,
  input  logic          wrap,
  input  logic          tick,
  input  logic          estop_set,
  input  logic          estop_clr,
  output logic          in_a,
  output logic          in_b,
  output logic [DW-1:0] duty,
  output logic          busy,
  output motor_state_e  state
);

  motor_state_e  state_q, state_d;
  logic [DW-1:0] ramp_q, ramp_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [TW-1:0] dead_q, dead_d;
  logic          dir_q, dir_d;
  logic          in_a_q, in_a_d;
  logic          in_b_q, in_b_d;
  logic [DW-1:0] cmd_goal;
  logic [DW-1:0] ramp_goal;
  logic          ramp_en;

  // One ramp step toward goal; never overshoots, never wraps.
  function automatic logic [DW-1:0] ramp_step(input logic [DW-1:0] cur,
                                              input logic [DW-1:0] goal);
    if (cur < goal) begin
      return ((goal - cur) > DW'(RAMP_INC)) ? cur + DW'(RAMP_INC) : goal;
    end
    return ((cur - goal) > DW'(RAMP_INC)) ? cur - DW'(RAMP_INC) : goal;
  endfunction

  assign cmd_goal = !cmd[CMD_EN] ? '0 :
                    (cmd[CMD_SPD] ? DW'(PWM_PERIOD) : DW'(HALF_DUTY));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ramp_q  <= '0;
      duty_q  <= '0;
      dead_q  <= '0;
      dir_q   <= 1'b0;
      in_a_q  <= 1'b0;
      in_b_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      dir_q   <= dir_d;
      in_a_q  <= in_a_d;
      in_b_q  <= in_b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ramp_d    = ramp_q;
    duty_d    = duty_q;
    dead_d    = dead_q;
    dir_d     = dir_q;
    in_a_d    = in_a_q;
    in_b_d    = in_b_q;
    ramp_goal = '0;
    ramp_en   = 1'b0;

    if (estop_set) begin
      // E-stop overrides every state and command: brake, no drive.
      state_d = ESTOP;
      ramp_d  = '0;
      dead_d  = '0;
      in_a_d  = 1'b1;
      in_b_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          ramp_d = '0;
          if (cmd[CMD_EN]) begin
            dir_d   = cmd[CMD_DIR];
            in_a_d  = cmd[CMD_DIR];
            in_b_d  = ~cmd[CMD_DIR];
            state_d = RUN;
          end
        end
        RUN: begin
          ramp_en = 1'b1;
          if (!cmd[CMD_EN] || (cmd[CMD_DIR] != dir_q)) begin
            state_d   = STOP;
            ramp_goal = '0;
          end else begin
            ramp_goal = cmd_goal;
          end
        end
        STOP: begin
          // Wait for the applied duty (not just the ramp) to reach zero so
          // the bridge is never switched while still being driven.
          if (duty_q == '0) begin
            ramp_d  = '0;
            in_a_d  = 1'b0;
            in_b_d  = 1'b0;
            dead_d  = TW'(DEADTIME_CYCLES);
            state_d = cmd[CMD_EN] ? DEAD : IDLE;
          end else begin
            ramp_en   = 1'b1;
            ramp_goal = '0;
          end
        end
        DEAD: begin
          // Dir is sampled only at the end, so toggling it back and forth
          // during STOP/DEAD cannot shorten the coast.
          if (!cmd[CMD_EN]) begin
            dead_d  = '0;
            state_d = IDLE;
          end else if (dead_q <= TW'(1)) begin
            dead_d  = '0;
            dir_d   = cmd[CMD_DIR];
            in_a_d  = cmd[CMD_DIR];
            in_b_d  = ~cmd[CMD_DIR];
            state_d = RUN;
          end else begin
            dead_d = dead_q - TW'(1);
          end
        end
        ESTOP: begin
          ramp_d = '0;
          if (estop_clr) begin
            in_a_d  = 1'b0;
            in_b_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          ramp_d  = '0;
          in_a_d  = 1'b0;
          in_b_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end

    if (ramp_en && tick) begin
      ramp_d = ramp_step(ramp_q, ramp_goal);
    end

    // Applied duty follows the ramp only at PWM wrap (no runt pulses);
    // e-stop cuts it immediately.
    if (estop_set) begin
      duty_d = '0;
    end else if (wrap) begin
      duty_d = ramp_d;
    end
  end

  assign in_a  = in_a_q;
  assign in_b  = in_b_q;
  assign duty  = duty_q;
  assign busy  = (state_q != IDLE);
  assign state = state_q;

endmodule

// File: rtl/trolley_motor_driver.sv
// Drive end of the motor_l/motor_r command words: registers the commands,
// runs the shared PWM counter and ramp step timer, latches the proximity
// e-stop and instantiates one motor_channel per motor.
// Ports:
//   clk_clk     : system clock
//   reset_reset : synchronous reset, active-high
//   bus         : trolley_motor_driver_if.slave (commands, prox_stop,
//                 bridge pins, estop_latched, busy, debug states)
module trolley_motor_driver
  import trolley_motor_pkg::*;
#(
  parameter int PWM_PERIOD       = 2500,
  parameter int HALF_DUTY        = 1250,
  parameter int RAMP_INC         = 125,
  parameter int RAMP_STEP_CYCLES = 50000,
  parameter int DEADTIME_CYCLES  = 50000
) (
  input logic                   clk_clk,
  input logic                   reset_reset,
  trolley_motor_driver_if.slave bus
);

  localparam int DW = duty_width(PWM_PERIOD);
  localparam int SW = duty_width(RAMP_STEP_CYCLES);

  logic [2:0]    cmd_l_q;
  logic [2:0]    cmd_r_q;
  logic [DW-1:0] pwm_cnt;
  logic [SW-1:0] step_cnt;
  logic          estop_q;
  logic          wrap;
  logic          tick;
  logic          estop_clr;
  logic [DW-1:0] duty_l;
  logic [DW-1:0] duty_r;
  logic          busy_l;
  logic          busy_r;

  assign wrap = (pwm_cnt == DW'(PWM_PERIOD - 1));
  assign tick = (step_cnt == SW'(RAMP_STEP_CYCLES - 1));

  // Release needs the stop input gone and both enables low in the same
  // cycle; a new prox_stop in that cycle wins.
  assign estop_clr = estop_q && !bus.prox_stop &&
                     !bus.motor_l_cmd[CMD_EN] && !bus.motor_r_cmd[CMD_EN];

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cmd_l_q  <= '0;
      cmd_r_q  <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
      estop_q  <= 1'b0;
    end else begin
      cmd_l_q  <= bus.motor_l_cmd;
      cmd_r_q  <= bus.motor_r_cmd;
      pwm_cnt  <= wrap ? '0 : pwm_cnt + DW'(1);
      step_cnt <= tick ? '0 : step_cnt + SW'(1);
      if (bus.prox_stop) begin
        estop_q <= 1'b1;
      end else if (estop_clr) begin
        estop_q <= 1'b0;
      end
    end
  end

  motor_channel #(
    .PWM_PERIOD      (PWM_PERIOD),
    .HALF_DUTY       (HALF_DUTY),
    .RAMP_INC        (RAMP_INC),
    .DEADTIME_CYCLES (DEADTIME_CYCLES)
  ) u_left (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .cmd       (cmd_l_q),
    .wrap      (wrap),
    .tick      (tick),
    .estop_set (bus.prox_stop),
    .estop_clr (estop_clr),
    .in_a      (bus.motor_l_in_a),
    .in_b      (bus.motor_l_in_b),
    .duty      (duty_l),
    .busy      (busy_l),
    .state     (bus.state_l)
  );

  motor_channel #(
    .PWM_PERIOD      (PWM_PERIOD),
    .HALF_DUTY       (HALF_DUTY),
    .RAMP_INC        (RAMP_INC),
    .DEADTIME_CYCLES (DEADTIME_CYCLES)
  ) u_right (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .cmd       (cmd_r_q),
    .wrap      (wrap),
    .tick      (tick),
    .estop_set (bus.prox_stop),
    .estop_clr (estop_clr),
    .in_a      (bus.motor_r_in_a),
    .in_b      (bus.motor_r_in_b),
    .duty      (duty_r),
    .busy      (busy_r),
    .state     (bus.state_r)
  );

  // Duty 0 gives constant low, duty PWM_PERIOD constant high.
  assign bus.motor_l_pwm   = (pwm_cnt < duty_l);
  assign bus.motor_r_pwm   = (pwm_cnt < duty_r);
  assign bus.estop_latched = estop_q;
  assign bus.busy          = {busy_r, busy_l};

endmodule

// File: tb/tb_trolley_motor_driver.sv
// Directed scenarios followed by randomized commands, every cycle checked
// against a behavioural model of the motor driver rules.
module tb_trolley_motor_driver;

  localparam int P   = 10;
  localparam int H   = 5;
  localparam int INC = 5;
  localparam int S   = 10;
  localparam int D   = 20;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STOP  = 2;
  localparam int M_DEAD  = 3;
  localparam int M_ESTOP = 4;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] l_cmd = 3'b000;
  logic [2:0] r_cmd = 3'b000;
  logic       px = 1'b0;

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  trolley_motor_driver_if bus ();

  assign bus.motor_l_cmd = l_cmd;
  assign bus.motor_r_cmd = r_cmd;
  assign bus.prox_stop   = px;

  trolley_motor_driver #(
    .PWM_PERIOD       (P),
    .HALF_DUTY        (H),
    .RAMP_INC         (INC),
    .RAMP_STEP_CYCLES (S),
    .DEADTIME_CYCLES  (D)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  // behavioural model
  int m_cmd[2]  = '{0, 0};
  int m_mode[2] = '{0, 0};
  int m_ramp[2] = '{0, 0};
  int m_duty[2] = '{0, 0};
  int m_dead[2] = '{0, 0};
  int m_dir[2]  = '{0, 0};
  int m_a[2]    = '{0, 0};
  int m_b[2]    = '{0, 0};
  int m_cnt = 0;
  int m_step = 0;
  int m_estop = 0;

  function automatic int approach(input int x, input int g);
    if (x < g) return (x + INC > g) ? g : x + INC;
    return (x - INC < g) ? g : x - INC;
  endfunction

  task automatic model_edge();
    int wrap, tick, clr, c, en, dir, goal, nr;
    if (rst) begin
      m_cnt = 0; m_step = 0; m_estop = 0;
      for (int ch = 0; ch < 2; ch++) begin
        m_cmd[ch] = 0; m_mode[ch] = M_IDLE; m_ramp[ch] = 0; m_duty[ch] = 0;
        m_dead[ch] = 0; m_dir[ch] = 0; m_a[ch] = 0; m_b[ch] = 0;
      end
      return;
    end
    wrap = (m_cnt == P - 1);
    tick = (m_step == S - 1);
    clr  = (m_estop == 1 && px == 1'b0 && l_cmd[2] == 1'b0 && r_cmd[2] == 1'b0);
    for (int ch = 0; ch < 2; ch++) begin
      c    = m_cmd[ch];
      en   = (c >> 2) & 1;
      dir  = (c >> 1) & 1;
      goal = (en == 0) ? 0 : (((c & 1) == 1) ? P : H);
      nr   = m_ramp[ch];
      if (px) begin
        m_mode[ch] = M_ESTOP; nr = 0; m_a[ch] = 1; m_b[ch] = 1;
      end else begin
        case (m_mode[ch])
          M_IDLE: begin
            nr = 0;
            if (en == 1) begin
              m_dir[ch] = dir; m_a[ch] = dir; m_b[ch] = 1 - dir; m_mode[ch] = M_RUN;
            end
          end
          M_RUN: begin
            if (en == 0 || dir != m_dir[ch]) begin
              m_mode[ch] = M_STOP;
              if (tick) nr = approach(nr, 0);
            end else if (tick) begin
              nr = approach(nr, goal);
            end
          end
          M_STOP: begin
            if (m_duty[ch] == 0) begin
              nr = 0; m_a[ch] = 0; m_b[ch] = 0; m_dead[ch] = D;
              m_mode[ch] = (en == 1) ? M_DEAD : M_IDLE;
            end else if (tick) begin
              nr = approach(nr, 0);
            end
          end
          M_DEAD: begin
            if (en == 0) begin
              m_mode[ch] = M_IDLE;
            end else if (m_dead[ch] <= 1) begin
              m_dir[ch] = dir; m_a[ch] = dir; m_b[ch] = 1 - dir; m_mode[ch] = M_RUN;
            end else begin
              m_dead[ch] = m_dead[ch] - 1;
            end
          end
          default: begin
            nr = 0;
            if (clr) begin
              m_mode[ch] = M_IDLE; m_a[ch] = 0; m_b[ch] = 0;
            end
          end
        endcase
      end
      m_ramp[ch] = nr;
      if (px) m_duty[ch] = 0;
      else if (wrap) m_duty[ch] = nr;
    end
    m_cnt   = wrap ? 0 : m_cnt + 1;
    m_step  = tick ? 0 : m_step + 1;
    m_estop = px ? 1 : (clr ? 0 : m_estop);
    m_cmd[0] = int'(l_cmd);
    m_cmd[1] = int'(r_cmd);
  endtask

  function automatic logic [8:0] model_outputs();
    logic [8:0] e;
    e[8] = (m_a[0] != 0);
    e[7] = (m_b[0] != 0);
    e[6] = (m_cnt < m_duty[0]);
    e[5] = (m_a[1] != 0);
    e[4] = (m_b[1] != 0);
    e[3] = (m_cnt < m_duty[1]);
    e[2] = (m_estop != 0);
    e[1] = (m_mode[1] != M_IDLE);
    e[0] = (m_mode[0] != M_IDLE);
    return e;
  endfunction

  function automatic logic [8:0] dut_outputs();
    return {bus.motor_l_in_a, bus.motor_l_in_b, bus.motor_l_pwm,
            bus.motor_r_in_a, bus.motor_r_in_b, bus.motor_r_pwm,
            bus.estop_latched, bus.busy};
  endfunction

  // scoreboard: one clock, model update, compare #1 after the edge
  task automatic tick_clk();
    logic [8:0] got, want;
    @(posedge clk);
    model_edge();
    #1;
    got  = dut_outputs();
    want = model_outputs();
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL outputs t=%0t observed=%b required=%b", $time, got, want);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_clk();
  endtask

  task automatic check(input string tag, input int obs, input int req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
    end
  endtask

  task automatic count_l_pwm(output int n);
    n = 0;
    for (int i = 0; i < P; i++) begin
      tick_clk();
      if (bus.motor_l_pwm) n++;
    end
  endtask

  // Cycles during which the left bridge coasts (in_a = in_b = 0).
  task automatic measure_coast(output int len);
    int guard;
    guard = 0;
    len = 0;
    while (!(bus.motor_l_in_a == 1'b0 && bus.motor_l_in_b == 1'b0) && guard < 300) begin
      tick_clk();
      guard++;
    end
    while (bus.motor_l_in_a == 1'b0 && bus.motor_l_in_b == 1'b0 && len < 300) begin
      tick_clk();
      len++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;

    // reset
    rst = 1'b1;
    ticks(3);
    check("reset_outputs", int'(dut_outputs()), 0);
    #1 rst = 1'b0;

    // 1: start forward full
    l_cmd = 3'b111;
    tick_clk();
    check("s1_in_a_after_1", int'(bus.motor_l_in_a), 0);
    tick_clk();
    check("s1_in_a_after_2", int'(bus.motor_l_in_a), 1);
    check("s1_in_b_after_2", int'(bus.motor_l_in_b), 0);
    ticks(60);
    count_l_pwm(n);
    check("s1_full_high", n, P);

    // 2: full -> half
    l_cmd = 3'b110;
    ticks(40);
    count_l_pwm(n);
    check("s2_half_high", n, H);

    // 3: reversal with dead time
    l_cmd = 3'b111;
    ticks(40);
    l_cmd = 3'b101;
    measure_coast(n);
    check("s3_coast_len", n, D);
    check("s3_in_a_rev", int'(bus.motor_l_in_a), 0);
    check("s3_in_b_rev", int'(bus.motor_l_in_b), 1);
    ticks(40);

    // 4: e-stop pulse while both run
    r_cmd = 3'b111;
    ticks(40);
    px = 1'b1;
    tick_clk();
    px = 1'b0;
    check("s4_estop", int'(bus.estop_latched), 1);
    check("s4_pwm_l", int'(bus.motor_l_pwm), 0);
    check("s4_pwm_r", int'(bus.motor_r_pwm), 0);
    check("s4_brake_l", int'({bus.motor_l_in_a, bus.motor_l_in_b}), 3);
    check("s4_brake_r", int'({bus.motor_r_in_a, bus.motor_r_in_b}), 3);
    ticks(20);
    check("s4_held", int'(bus.estop_latched), 1);
    l_cmd = 3'b000;
    ticks(3);
    check("s4_held_one_en", int'(bus.estop_latched), 1);
    r_cmd = 3'b000;
    tick_clk();
    check("s4_cleared", int'(bus.estop_latched), 0);
    check("s4_busy_cleared", int'(bus.busy), 0);

    // 5: dir toggled back during STOP
    l_cmd = 3'b111;
    ticks(50);
    l_cmd = 3'b101;
    ticks(3);
    l_cmd = 3'b111;
    measure_coast(n);
    check("s5_coast_len", n, D);
    check("s5_resume_fwd", int'({bus.motor_l_in_a, bus.motor_l_in_b}), 2);

    // 6: reset mid-ramp and mid-DEAD
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    l_cmd = 3'b111;
    ticks(14);
    rst = 1'b1;
    tick_clk();
    check("s6_reset_mid_ramp", int'(dut_outputs()), 0);
    rst = 1'b0;
    ticks(40);
    l_cmd = 3'b101;
    guard = 0;
    while (!(bus.motor_l_in_a == 1'b0 && bus.motor_l_in_b == 1'b0) && guard < 300) begin
      tick_clk();
      guard++;
    end
    check("s6_reached_dead", int'(guard < 300), 1);
    ticks(5);
    rst = 1'b1;
    tick_clk();
    check("s6_reset_mid_dead", int'(dut_outputs()), 0);
    rst = 1'b0;
    l_cmd = 3'b000;

    // randomized commands, e-stops and resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) l_cmd = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) r_cmd = 3'($urandom_range(0, 7));
      px  = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick_clk();
    end
    px = 1'b0;
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
